ic_7458_bist: RTL

Built-in self-test sequencer for the 7458 quad-AND/dual-OR block. It sits directly upstream of the 7458 and drives all 10 of its inputs. It also consumes the two outputs, `p1y` and `p2y`, and compares them against a golden model. On each start it sweeps all 1024 input combinations, counts mismatches and records the first failing vector.

---
 rtl/ic_7458_bist.sv | 131 +++++++++++++
 1 files changed

// File: rtl/ic_7458_bist.sv
// Exhaustive BIST sequencer for the 7458 quad-AND/dual-OR block: drives all 1024 vectors, counts mismatches.
// Build macro IC_7458_BIST_STOP_ON_ERR_EN: end the sweep on the first mismatching vector.
module ic_7458_bist #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned ERR_W         = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             p1a,
    output logic             p1b,
    output logic             p1c,
    output logic             p1d,
    output logic             p1e,
    output logic             p1f,
    output logic             p2a,
    output logic             p2b,
    output logic             p2c,
    output logic             p2d,
    input  logic             p1y,
    input  logic             p2y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [9:0]       first_err_vec
);
    localparam int unsigned VEC_W = 10;
    localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [VEC_W-1:0] VEC_LAST = '1;
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    typedef enum logic [1:0] {ST_IDLE, ST_APPLY, ST_CHECK, ST_DONE} state_e;

    state_e             state_q, state_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic [SET_W-1:0]   settle_q, settle_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [VEC_W-1:0]   first_q, first_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic               exp1, exp2, mismatch, stop;

    // Golden 7458 model evaluated against the live outputs during CHECK
    always_comb begin
        exp1     = (vec_q[0] & vec_q[1] & vec_q[2]) | (vec_q[3] & vec_q[4] & vec_q[5]);
        exp2     = (vec_q[6] & vec_q[7]) | (vec_q[8] & vec_q[9]);
        mismatch = (p1y != exp1) || (p2y != exp2);
`ifdef IC_7458_BIST_STOP_ON_ERR_EN
        stop     = mismatch || (vec_q == VEC_LAST);
`else
        stop     = (vec_q == VEC_LAST);
`endif
    end

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        settle_d = settle_q;
        err_d    = err_q;
        first_d  = first_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d  = ST_APPLY;
                    vec_d    = '0;
                    settle_d = '0;
                    err_d    = '0;
                    first_d  = '0;
                end
            end
            ST_APPLY: begin
                if (settle_q == SET_LAST) begin
                    state_d = ST_CHECK;
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end
            ST_CHECK: begin
                settle_d = '0;
                if (mismatch) begin
                    if (err_q != ERR_MAX) err_d = err_q + ERR_W'(1);
                    if (err_q == '0)      first_d = vec_q;
                end
                if (stop) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_APPLY;
                    vec_d   = vec_q + VEC_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Status flags registered from the next state so they align with it
        busy_d = (state_d == ST_APPLY) || (state_d == ST_CHECK);
        done_d = (state_d == ST_DONE);
        pass_d = done_d && (err_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            vec_q    <= '0;
            settle_q <= '0;
            err_q    <= '0;
            first_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            settle_q <= settle_d;
            err_q    <= err_d;
            first_q  <= first_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
        end
    end

    assign {p2d, p2c, p2b, p2a, p1f, p1e, p1d, p1c, p1b, p1a} = vec_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_count     = err_q;
    assign first_err_vec = first_q;

endmodule
